fibonacci_seq: RTL and testbench
================================

FIBONACCI_SEQ -- requirements
Module: fibonacci_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-high reset (asserted at 1, sampled on clk rising edge); the name is kept per codebase convention.
REQ-004 address  input  2  register select: 0=N, 1=CONTROL, 2=STATUS, 3=RESULT.
REQ-005 chipselect  input  1  qualifies read/write; access ignored when 0.
REQ-006 read  input  1  read strobe.
REQ-007 write  input  1  write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  read data.
REQ-010 Parameter MAX_N, default 47, largest index whose Fibonacci value fits in 32 bits unsigned.

Function
REQ-011 Sequence definition SHALL be F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2), unsigned 32-bit.
REQ-012 Write with chipselect=1, address=0 SHALL load N register (all 32 bits) when not busy; ignored while busy.
REQ-013 Write with chipselect=1, address=1, writedata[0]=1 SHALL start computation when not busy; ignored while busy; CONTROL is self-clearing and reads as 0.
REQ-014 Writes to addresses 2 and 3 SHALL be ignored.
REQ-015 FSM states IDLE, CALC, DONE; reset -> IDLE.
REQ-016 On accepted start with N<=MAX_N: load a=0, b=1, cnt=N, clear done/overflow, set busy, enter CALC.
REQ-017 Each CALC cycle: if cnt==0 then RESULT<=a, done<=1, busy<=0, enter DONE; else a<=b, b<=a+b (32-bit), cnt<=cnt-1.
REQ-018 Latency: done=1 and RESULT valid exactly N+1 clock edges after the start write edge.
REQ-019 On accepted start with N>MAX_N: next edge SHALL set RESULT=0xFFFFFFFF, overflow=1, done=1, busy=0, enter DONE.
REQ-020 DONE behaves as IDLE for new writes; a new start clears done and overflow.
REQ-021 readdata SHALL be combinational: chipselect&read ? selected register : 0.
REQ-022 Read map: 0 -> N; 1 -> 0; 2 -> {29'b0, overflow, busy, done}; 3 -> RESULT.
REQ-023 RESULT SHALL hold its last value during a new computation until that computation completes.
REQ-024 Simultaneous read and write in the same cycle SHALL perform both; readdata reflects pre-edge register values.

Reset
REQ-025 While reset_n=1 at a clock edge: state IDLE, N=0, RESULT=0, a=0, b=0, cnt=0, done=0, busy=0, overflow=0; readdata therefore 0 or register values of 0.
REQ-026 Reset asserted mid-computation SHALL abort it; no done is produced afterward.

Structure
REQ-027 Shared package SHALL hold address constants (ADDR_N, ADDR_CTRL, ADDR_STATUS, ADDR_RESULT), status bit positions, MAX_N, and the FSM state enum.
REQ-028 One sub-module fib_core (FSM, a/b/cnt datapath, overflow decision) SHALL be instantiated under the Avalon register wrapper.

Verification
REQ-029 N=21, start, poll STATUS -> done=1 after 22 edges; RESULT=10946 (0x2AC2); overflow=0.
REQ-030 N=80 then N=145, each started -> done=1 one edge after start; overflow=1; RESULT=0xFFFFFFFF.
REQ-031 Boundary: N=0 -> RESULT=0; N=1 -> RESULT=1; N=47 -> RESULT=2971215073 (0xB11924E1), overflow=0; N=48 -> overflow=1.
REQ-032 Start N=30, then write N=5 and start again while busy -> both ignored; RESULT=832040; N register still reads 30.
REQ-033 Start N=40, assert reset_n=1 after 10 edges -> STATUS=0, RESULT=0, no later done.
REQ-034 chipselect=0 with read=1 -> readdata=0; chipselect=0 write to address 1 -> no start.

Source files
------------

// File: rtl/fibonacci_seq_pkg.sv
// Shared constants for the Fibonacci register block: address map, status bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fibonacci_seq_pkg;

  // Register address map
  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // Bit positions inside the STATUS word
  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 2;

  // Largest index whose Fibonacci value fits in 32 bits unsigned
  localparam int unsigned MAX_N_DEFAULT = 47;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pack the three status flags into the 32-bit STATUS read value
  function automatic logic [31:0] status_word(input logic done, input logic busy,
                                              input logic overflow);
    logic [31:0] s;
    s            = '0;
    s[STAT_DONE] = done;
    s[STAT_BUSY] = busy;
    s[STAT_OVF]  = overflow;
    return s;
  endfunction

endpackage

// File: rtl/fibonacci_seq_fib_core.sv
// Iterative Fibonacci engine: FSM plus a/b/cnt datapath and out-of-range detection.
// Latency: done rises N+1 edges after the start edge (1 edge when N exceeds MAX_N).
// Backpressure: none; start is ignored while busy.
module fib_core
  import fibonacci_seq_pkg::*;
#(
  parameter int unsigned MAX_N = MAX_N_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] n,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [31:0] result
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] cnt;
  logic        ovf_pend;   // remembers that the accepted N was out of range
  logic        load;
  logic        finish;

  // State register
  always_ff @(posedge clk) begin
    if (reset_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        // Out-of-range requests complete on the first CALC edge
        if (ovf_pend || cnt == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: seed on start, step a/b each CALC cycle, latch the result on finish
  always_ff @(posedge clk) begin
    if (reset_n) begin
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      ovf_pend <= 1'b0;
    end else if (load) begin
      a        <= 32'd0;
      b        <= 32'd1;
      cnt      <= n;
      ovf_pend <= (n > 32'(MAX_N));
      done     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b1;
    end else if (finish) begin
      result   <= ovf_pend ? 32'hFFFF_FFFF : a;
      overflow <= ovf_pend;
      ovf_pend <= 1'b0;
      done     <= 1'b1;
      busy     <= 1'b0;
    end else if (state == CALC) begin
      a   <= b;
      b   <= a + b;
      cnt <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/fibonacci_seq.sv
// Memory-mapped register wrapper around fib_core (N, CONTROL, STATUS, RESULT).
// Latency: reads are combinational; a start completes N+1 edges later.
// Backpressure: none; N and CONTROL writes are dropped while a computation is running.
module fibonacci_seq
  import fibonacci_seq_pkg::*;
#(
  parameter int unsigned MAX_N = MAX_N_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  logic [31:0] n_reg;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        wr_access;
  logic        start;

  assign wr_access = chipselect && write;
  // CONTROL is a pulse: bit 0 requests a start and nothing is stored
  assign start     = wr_access && (address == ADDR_CTRL) && writedata[0] && !busy;

  // N register: writable only while the engine is not running
  always_ff @(posedge clk) begin
    if (reset_n)                                       n_reg <= '0;
    else if (wr_access && address == ADDR_N && !busy) n_reg <= writedata;
  end

  fib_core #(
    .MAX_N (MAX_N)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .n        (n_reg),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .result   (result)
  );

  // Combinational read mux; returns zero unless a qualified read is present
  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        ADDR_N:      readdata = n_reg;
        ADDR_CTRL:   readdata = '0;
        ADDR_STATUS: readdata = status_word(done, busy, overflow);
        ADDR_RESULT: readdata = result;
        default:     readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_seq.sv
// Self-checking bench for fibonacci_seq: scoreboard of expected read data vs. monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_fibonacci_seq;
  import fibonacci_seq_pkg::*;

  localparam int unsigned MAXN = 47;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  fibonacci_seq #(.MAX_N(MAXN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  // Reference model: countdown to completion plus precomputed answer
  logic [31:0] m_n = '0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend = '0;
  bit          m_done = 0, m_busy = 0, m_ovf = 0, m_povf = 0;
  int          m_left = 0;

  // Scoreboard
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] ref_fib(input logic [31:0] k);
    longint unsigned x = 0, y = 1, t;
    for (longint unsigned i = 0; i < longint'(k); i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x[31:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    case (addr)
      2'd0:    return m_n;
      2'd1:    return 32'd0;
      2'd2:    return {29'd0, m_ovf, m_busy, m_done};
      default: return m_result;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit cs, input bit wr,
                            input logic [1:0] addr, input logic [31:0] wd);
    if (rst) begin
      m_n = '0; m_result = '0; m_pend = '0;
      m_done = 0; m_busy = 0; m_ovf = 0; m_povf = 0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_result = m_pend; m_ovf = m_povf;
      end
    end else if (cs && wr) begin
      if (addr == 2'd0) m_n = wd;
      else if (addr == 2'd1 && wd[0]) begin
        m_busy = 1; m_done = 0; m_ovf = 0;
        if (m_n > MAXN) begin
          m_left = 1; m_pend = 32'hFFFF_FFFF; m_povf = 1;
        end else begin
          m_left = int'(m_n) + 1; m_pend = ref_fib(m_n); m_povf = 0;
        end
      end
    end
  endtask

  // Drive one bus cycle; expected read data comes from the pre-edge model state
  task automatic cycle(input bit rst, input bit cs, input bit rd, input bit wr,
                       input logic [1:0] addr, input logic [31:0] wd, input string tag);
    reset_n = rst; chipselect = cs; read = rd; write = wr; address = addr; writedata = wd;
    if (rd) begin
      exp_q.push_back(cs ? model_read(addr) : 32'd0);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    model_edge(rst, cs, wr, addr, wd);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [31:0] d);
    cycle(0, 1, 0, 1, addr, d, "");
  endtask

  task automatic rd_reg(input logic [1:0] addr, input string tag);
    cycle(0, 1, 1, 0, addr, 32'd0, tag);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (m_busy && k < 300) begin
      rd_reg(ADDR_STATUS, tag);
      k++;
    end
  endtask

  task automatic run_n(input logic [31:0] n, input string tag);
    wr_reg(ADDR_N, n);
    wr_reg(ADDR_CTRL, 32'd1);
    wait_done({tag, "_poll"});
    rd_reg(ADDR_STATUS, {tag, "_status"});
    rd_reg(ADDR_RESULT, {tag, "_result"});
    rd_reg(ADDR_N, {tag, "_nreg"});
  endtask

  // Monitor: compare each presented read against the oldest expectation
  always @(negedge clk) begin
    if (read) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read: readdata=0x%08h expected=<none>", readdata);
      end else begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (readdata !== e) begin
          n_bad++;
          $display("FAIL %s: readdata=0x%08h expected=0x%08h", t, readdata, e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then read every register while reset is still held
    cycle(1, 0, 0, 0, 2'd0, 32'd0, "");
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 2'(i), 32'd0, "reset_read");
    for (int i = 0; i < 4; i++) rd_reg(2'(i), "post_reset_read");

    run_n(32'd21, "n21");
    run_n(32'd80, "n80");
    run_n(32'd145, "n145");
    run_n(32'd0, "n0");
    run_n(32'd1, "n1");
    run_n(32'd47, "n47");
    run_n(32'd48, "n48");

    // Writes while busy are dropped
    wr_reg(ADDR_N, 32'd30);
    wr_reg(ADDR_CTRL, 32'd1);
    wr_reg(ADDR_N, 32'd5);
    wr_reg(ADDR_CTRL, 32'd1);
    wait_done("busy_ign_poll");
    rd_reg(ADDR_RESULT, "busy_ign_result");
    rd_reg(ADDR_N, "busy_ign_nreg");

    // Reset in the middle of a computation
    wr_reg(ADDR_N, 32'd40);
    wr_reg(ADDR_CTRL, 32'd1);
    for (int i = 0; i < 9; i++) rd_reg(ADDR_STATUS, "abort_pre");
    cycle(1, 1, 1, 0, ADDR_STATUS, 32'd0, "abort_at_reset");
    rd_reg(ADDR_STATUS, "abort_status");
    rd_reg(ADDR_RESULT, "abort_result");
    for (int i = 0; i < 60; i++) rd_reg(ADDR_STATUS, "abort_no_done");

    // chipselect low: read returns 0, write to CONTROL starts nothing
    wr_reg(ADDR_N, 32'd3);
    cycle(0, 0, 1, 0, ADDR_N, 32'd0, "nocs_read");
    cycle(0, 0, 0, 1, ADDR_CTRL, 32'd1, "");
    rd_reg(ADDR_STATUS, "nocs_no_start");
    // Simultaneous read and write returns the pre-edge value
    cycle(0, 1, 1, 1, ADDR_N, 32'd9, "rw_same_cycle");
    rd_reg(ADDR_N, "rw_after");
    cycle(0, 1, 1, 1, ADDR_RESULT, 32'hDEAD_BEEF, "rw_result_ro");
    rd_reg(ADDR_RESULT, "rw_result_after");

    // Randomized runs with random bus traffic during computation
    for (int it = 0; it < 25; it++) begin
      logic [31:0] n;
      int          k;
      n = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 50));
      wr_reg(ADDR_N, n);
      cycle(0, 1, 1, 1, ADDR_CTRL, 32'd1, "rnd_start");
      k = 0;
      while (m_busy && k < 300) begin
        cycle(0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
              2'($urandom), 32'($urandom), "rnd_busy");
        k++;
      end
      rd_reg(ADDR_STATUS, "rnd_status");
      rd_reg(ADDR_RESULT, "rnd_result");
    end

    cycle(0, 0, 0, 0, 2'd0, 32'd0, "");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
